// File: rtl/plot_fb_pkg.sv
// Shared types and defaults for the pixel-plot framebuffer writer.
// The PLOT_FB_STATS_EN option is handled in plot_fb_writer.
package plot_fb_pkg;

   localparam int DEF_WIDTH    = 160;
   localparam int DEF_HEIGHT   = 120;
   localparam int PIX_COLOUR_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      DONE
   } state_t;

   // Colour is stored at the widest supported size; the writer narrows it back to COLOUR_W.
   typedef struct packed {
      logic [7:0]              x;
      logic [6:0]              y;
      logic [PIX_COLOUR_W-1:0] colour;
   } pixel_t;

endpackage

// File: rtl/plot_fifo.sv
// Show-ahead synchronous FIFO of pixels. A push is accepted when the FIFO is full
// if a pop happens in the same cycle. The occupancy count is exposed.
module plot_fifo
   import plot_fb_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           push,
   input  pixel_t         wr_data,
   input  logic           pop,
   output pixel_t         rd_data,
   output logic           full,
   output logic           empty,
   output logic [PTR_W:0] count
);

   pixel_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic             pop_ok;
   logic             push_ok;

   assign full    = (count_reg == (PTR_W+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign rd_data = mem[rd_ptr_reg];

   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/plot_fb_writer.sv
// Converts plot strobes into linear framebuffer writes and runs full-screen clears.
// Optional PLOT_FB_STATS_EN adds drop_count and fifo_hwm outputs.
module plot_fb_writer
   import plot_fb_pkg::*;
#(
   parameter  int WIDTH      = DEF_WIDTH,
   parameter  int HEIGHT     = DEF_HEIGHT,
   parameter  int COLOUR_W   = 3,
   parameter  int FIFO_DEPTH = 8,
   localparam int ADDR_W     = $clog2(WIDTH*HEIGHT),
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [7:0]          plot_x,
   input  logic [6:0]          plot_y,
   input  logic [COLOUR_W-1:0] plot_colour,
   input  logic                plot_valid,
   input  logic                clr_start,
   input  logic [COLOUR_W-1:0] clr_colour,
   output logic                clr_done,
   output logic                busy,
   output logic                overflow,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [COLOUR_W-1:0] mem_wdata,
   output logic                mem_we
`ifdef PLOT_FB_STATS_EN
   ,
   output logic [15:0]         drop_count,
   output logic [CNT_W-1:0]    fifo_hwm
`endif
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH*HEIGHT - 1);

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   counter_reg, counter_next;
   logic [COLOUR_W-1:0] clr_colour_reg, clr_colour_next;
   logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
   logic [COLOUR_W-1:0] mem_wdata_reg, mem_wdata_next;
   logic                mem_we_reg, mem_we_next;
   logic                overflow_reg;

   pixel_t              pix_in;
   pixel_t              fifo_rd;
   logic                fifo_full;
   logic                fifo_empty;
   logic [CNT_W-1:0]    fifo_count;
   logic                in_range;
   logic                push;
   logic                pop;
   logic [ADDR_W-1:0]   pix_addr;

   assign in_range = (plot_x < 8'(WIDTH)) && (plot_y < 7'(HEIGHT));
   assign push     = plot_valid && in_range;

   always_comb begin
      pix_in        = '0;
      pix_in.x      = plot_x;
      pix_in.y      = plot_y;
      pix_in.colour = PIX_COLOUR_W'(plot_colour);
   end

   plot_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .wr_data (pix_in),
      .pop     (pop),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign pix_addr = ADDR_W'(fifo_rd.y) * ADDR_W'(WIDTH) + ADDR_W'(fifo_rd.x);

   always_comb begin
      state_next      = state_reg;
      counter_next    = counter_reg;
      clr_colour_next = clr_colour_reg;
      pop             = 1'b0;
      mem_we_next     = 1'b0;
      mem_addr_next   = mem_addr_reg;
      mem_wdata_next  = mem_wdata_reg;
      case (state_reg)
         IDLE: begin
            // Popping stops on the acceptance edge so queued plots land after the clear.
            if (clr_start) begin
               state_next      = CLEAR;
               counter_next    = '0;
               clr_colour_next = clr_colour;
            end else begin
               pop = !fifo_empty;
            end
         end
         CLEAR: begin
            mem_we_next    = 1'b1;
            mem_addr_next  = counter_reg;
            mem_wdata_next = clr_colour_reg;
            counter_next   = counter_reg + 1'b1;
            if (counter_reg == LAST_ADDR) begin
               state_next = DONE;
            end
         end
         DONE: begin
            pop = !fifo_empty;
            if (!clr_start) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (pop) begin
         mem_we_next    = 1'b1;
         mem_addr_next  = pix_addr;
         mem_wdata_next = COLOUR_W'(fifo_rd.colour);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         counter_reg    <= '0;
         clr_colour_reg <= '0;
         mem_we_reg     <= 1'b0;
         mem_addr_reg   <= '0;
         mem_wdata_reg  <= '0;
         overflow_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         counter_reg    <= counter_next;
         clr_colour_reg <= clr_colour_next;
         mem_we_reg     <= mem_we_next;
         mem_addr_reg   <= mem_addr_next;
         mem_wdata_reg  <= mem_wdata_next;
         if (push && fifo_full && !pop) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   assign mem_we    = mem_we_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;
   assign overflow  = overflow_reg;
   assign clr_done  = (state_reg == DONE);
   assign busy      = (state_reg == CLEAR) || (fifo_count != '0);

`ifdef PLOT_FB_STATS_EN
   logic [15:0]      drop_count_reg;
   logic [CNT_W-1:0] fifo_hwm_reg;
   logic             dropped;

   assign dropped = plot_valid && !(in_range && (!fifo_full || pop));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         drop_count_reg <= '0;
         fifo_hwm_reg   <= '0;
      end else begin
         if (dropped && (drop_count_reg != 16'hFFFF)) begin
            drop_count_reg <= drop_count_reg + 16'd1;
         end
         if (fifo_count > fifo_hwm_reg) begin
            fifo_hwm_reg <= fifo_count;
         end
      end
   end

   assign drop_count = drop_count_reg;
   assign fifo_hwm   = fifo_hwm_reg;
`endif

endmodule
